// File: rtl/test_freq_gen_if.sv
// Configuration write port of the test frequency generator: a one-cycle write
// strobe with channel, half-period and mode, answered by a one-cycle ack or error.
interface test_freq_gen_if #(
  parameter int DIV_WIDTH = 16
);
  logic                 cfg_we_i;
  logic [4:0]           cfg_ch_i;
  logic [DIV_WIDTH-1:0] cfg_half_i;
  logic [1:0]           cfg_mode_i;
  logic                 cfg_ack_o;
  logic                 cfg_err_o;

  modport master (
    output cfg_we_i, cfg_ch_i, cfg_half_i, cfg_mode_i,
    input  cfg_ack_o, cfg_err_o
  );

  modport slave (
    input  cfg_we_i, cfg_ch_i, cfg_half_i, cfg_mode_i,
    output cfg_ack_o, cfg_err_o
  );
endinterface

// File: rtl/test_freq_gen.sv
// Test frequency generator: CHANNELS independent 50 % duty square waves with a
// programmable half-period, per-channel run/invert/gate mode and a global phase sync.
module test_freq_gen #(
  parameter int CHANNELS  = 24,
  parameter int DIV_WIDTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  test_freq_gen_if.slave      cfg,
  input  logic [CHANNELS-1:0] gate_i,
  input  logic                sync_i,
  output logic [CHANNELS-1:0] f_o
);
  // mode | meaning
  // 00   | stopped, output held low, counter cleared
  // 01   | running, phase starts low
  // 10   | running, phase starts high (inverted)
  // 11   | running like 01, counter and output frozen while gate_i is low
  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_INV   = 2'b10;
  localparam logic [1:0] MODE_GATED = 2'b11;

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

  logic                 ch_ok;
  logic [DIV_WIDTH-1:0] half_eff;

  assign ch_ok    = ({1'b0, cfg.cfg_ch_i} < 6'(CHANNELS));
  assign half_eff = (cfg.cfg_half_i == '0) ? ONE : cfg.cfg_half_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg.cfg_ack_o <= 1'b0;
      cfg.cfg_err_o <= 1'b0;
    end else begin
      cfg.cfg_ack_o <= cfg.cfg_we_i & ch_ok;
      cfg.cfg_err_o <= cfg.cfg_we_i & ~ch_ok;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DIV_WIDTH-1:0] shadow_q;
    logic [DIV_WIDTH-1:0] active_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic [1:0]           mode_q;
    logic                 f_q;
    logic                 wr;
    logic                 running;
    logic                 inv_swap;
    logic                 gated_off;
    logic [1:0]           mode_next;

    assign wr        = cfg.cfg_we_i & ch_ok & (cfg.cfg_ch_i == 5'(g));
    assign running   = (mode_q != MODE_STOP);
    assign mode_next = wr ? cfg.cfg_mode_i : mode_q;
    assign inv_swap  = wr & (((mode_q == MODE_RUN) & (cfg.cfg_mode_i == MODE_INV)) |
                             ((mode_q == MODE_INV) & (cfg.cfg_mode_i == MODE_RUN)));
    assign gated_off = (mode_q == MODE_GATED) & ~gate_i[g];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        mode_q   <= MODE_STOP;
        shadow_q <= ONE;
        active_q <= ONE;
        cnt_q    <= '0;
        f_q      <= 1'b0;
      end else begin
        if (wr) begin
          shadow_q <= half_eff;
          mode_q   <= cfg.cfg_mode_i;
        end

        if (wr && (cfg.cfg_mode_i == MODE_STOP)) begin
          f_q   <= 1'b0;
          cnt_q <= '0;
        end else if (wr && !running) begin
          active_q <= half_eff;
          cnt_q    <= half_eff - ONE;
          f_q      <= (cfg.cfg_mode_i == MODE_INV);
        end else if (running) begin
          // sync re-phases from the active value already in force, not the new shadow
          if (sync_i) begin
            cnt_q <= active_q - ONE;
            f_q   <= (mode_next == MODE_INV);
          end else if (inv_swap) begin
            f_q <= ~f_q;
          end else if (!gated_off) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - ONE;
            end else begin
              f_q      <= ~f_q;
              active_q <= shadow_q;
              cnt_q    <= shadow_q - ONE;
            end
          end
        end
      end
    end

    assign f_o[g] = f_q;
  end
endmodule

// File: tb/tb_test_freq_gen.sv
// Bench for test_freq_gen (4 channels, 8-bit half-period): directed scenarios and
// random traffic, checked against a toggle-deadline model of each channel.
module tb_test_freq_gen;
  localparam int CH = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] gate = '1;
  logic          sync = 1'b0;
  logic [CH-1:0] f_o;

  test_freq_gen_if #(.DIV_WIDTH(DW)) cfg ();

  test_freq_gen #(.CHANNELS(CH), .DIV_WIDTH(DW)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .cfg    (cfg),
    .gate_i (gate),
    .sync_i (sync),
    .f_o    (f_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: each running channel knows the absolute edge at which it next toggles.
  logic [1:0] m_mode [CH];
  int         m_sh   [CH];
  int         m_act  [CH];
  int         m_dl   [CH];
  logic [CH-1:0] m_f = '0;
  logic       m_ack = 1'b0;
  logic       m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    cyc++;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_mode[i] = 2'b00; m_sh[i] = 1; m_act[i] = 1; m_dl[i] = 0; m_f[i] = 1'b0;
      end
      m_ack = 1'b0;
      m_err = 1'b0;
      return;
    end
    m_ack = cfg.cfg_we_i && (cfg.cfg_ch_i < CH);
    m_err = cfg.cfg_we_i && (cfg.cfg_ch_i >= CH);
    for (int i = 0; i < CH; i++) begin
      bit         wr;
      bit         run;
      int         h;
      logic [1:0] nm;
      wr  = cfg.cfg_we_i && (cfg.cfg_ch_i == i);
      run = (m_mode[i] != 2'b00);
      h   = (cfg.cfg_half_i == 0) ? 1 : int'(cfg.cfg_half_i);
      nm  = wr ? cfg.cfg_mode_i : m_mode[i];
      if (wr && cfg.cfg_mode_i == 2'b00) begin
        m_f[i] = 1'b0;
      end else if (wr && !run) begin
        m_act[i] = h;
        m_dl[i]  = cyc + h;
        m_f[i]   = (cfg.cfg_mode_i == 2'b10);
      end else if (run) begin
        if (sync) begin
          m_dl[i] = cyc + m_act[i];
          m_f[i]  = (nm == 2'b10);
        end else if (wr && ((m_mode[i] == 2'b01 && nm == 2'b10) ||
                            (m_mode[i] == 2'b10 && nm == 2'b01))) begin
          m_f[i] = ~m_f[i];
          m_dl[i]++;
        end else if (m_mode[i] == 2'b11 && !gate[i]) begin
          m_dl[i]++;
        end else if (cyc == m_dl[i]) begin
          m_f[i]   = ~m_f[i];
          m_act[i] = m_sh[i];
          m_dl[i]  = cyc + m_act[i];
        end
      end
      if (wr) begin
        m_sh[i]   = h;
        m_mode[i] = nm;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("f_o", 32'(f_o), 32'(m_f));
    chk("cfg_ack", 32'(cfg.cfg_ack_o), 32'(m_ack));
    chk("cfg_err", 32'(cfg.cfg_err_o), 32'(m_err));
    cfg.cfg_we_i = 1'b0;
    sync = 1'b0;
  endtask

  task automatic write(input int ch, input int half, input logic [1:0] mode);
    cfg.cfg_we_i   = 1'b1;
    cfg.cfg_ch_i   = 5'(ch);
    cfg.cfg_half_i = DW'(half);
    cfg.cfg_mode_i = mode;
  endtask

  initial begin
    cfg.cfg_we_i   = 1'b0;
    cfg.cfg_ch_i   = '0;
    cfg.cfg_half_i = '0;
    cfg.cfg_mode_i = 2'b00;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("reset_f", 32'(f_o), 32'h0);
    tick();

    // ch0 H=3 run: low 3 edges, high 3 edges, period 6; ack for one cycle
    write(0, 3, 2'b01);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("ch0_wave", 32'(f_o[0]), 32'((k / 3) % 2));
      if (k == 0) chk("ch0_ack_on", 32'(cfg.cfg_ack_o), 32'h1);
      if (k == 1) chk("ch0_ack_off", 32'(cfg.cfg_ack_o), 32'h0);
    end

    // ch1 H=2, rewritten to H=5 in the middle of its first high phase
    write(1, 2, 2'b01);
    for (int k = 0; k < 15; k++) begin
      if (k == 3) write(1, 5, 2'b01);
      tick();
      chk("ch1_retime", 32'(f_o[1]),
          32'((k < 2) ? 0 : (k < 4) ? 1 : (k < 9) ? 0 : (k < 14) ? 1 : 0));
    end

    // ch0/ch2 started out of phase, then aligned by sync
    write(0, 0, 2'b00); tick();
    write(0, 3, 2'b01); tick();
    tick();
    write(2, 3, 2'b01); tick();
    tick();
    sync = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("sync_ch0", 32'(f_o[0]), 32'((k / 3) % 2));
      chk("sync_ch2", 32'(f_o[2]), 32'((k / 3) % 2));
    end

    // ch3 gated H=1: frozen for 4 gated edges, then toggles every cycle again
    write(3, 1, 2'b11);
    for (int k = 0; k < 12; k++) begin
      gate[3] = (k >= 4 && k < 8) ? 1'b0 : 1'b1;
      tick();
      chk("ch3_gate", 32'(f_o[3]), 32'((k >= 4 && k < 8) ? 1 : k % 2));
    end
    gate = '1;

    // H=0 stored as 1 on ch2
    write(2, 0, 2'b01);
    repeat (6) tick();

    // out-of-range channel, then reset mid-run
    write(7, 3, 2'b01);
    tick();
    chk("bad_ch_err", 32'(cfg.cfg_err_o), 32'h1);
    chk("bad_ch_ack", 32'(cfg.cfg_ack_o), 32'h0);
    tick();
    chk("bad_ch_err_off", 32'(cfg.cfg_err_o), 32'h0);
    rst = 1'b1;
    tick();
    chk("rst_f", 32'(f_o), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("stopped_after_rst", 32'(f_o), 32'h0);
    end

    // maximum half-period, inverted start
    write(1, 255, 2'b10);
    for (int k = 0; k < 512; k++) begin
      tick();
      if (k == 254) chk("hmax_hi_end", 32'(f_o[1]), 32'h1);
      if (k == 255) chk("hmax_lo_start", 32'(f_o[1]), 32'h0);
      if (k == 509) chk("hmax_lo_end", 32'(f_o[1]), 32'h0);
      if (k == 510) chk("hmax_hi_again", 32'(f_o[1]), 32'h1);
    end

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(3) == 0) begin
        write($urandom_range(7),
              ($urandom_range(7) == 0) ? $urandom_range(255) : $urandom_range(6),
              2'($urandom_range(3)));
      end
      gate = CH'($urandom);
      sync = ($urandom_range(15) == 0);
      rst  = ($urandom_range(199) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
